seg7_bcd_display: RTL and testbench

Parametrised, multi-digit seven-segment display driver that succeeds the fixed five-display output stage of the datapath top level. It accepts a binary value through a valid/busy handshake and converts it to BCD with a sequential double-dabble engine, one bit per clock. It then drives DIGITS registered active-low segment patterns, with leading-zero blanking, overflow indication and optional signed display. It sits between the datapath result register and the FPGA display pins.

---
 rtl/seg7_bcd_display.sv | 168 ++++++++++++++++
 tb/tb_seg7_bcd_display.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_display.sv
// Multi-digit active-low seven-segment driver with a sequential double-dabble binary-to-BCD engine.
// Define SEG7_SIGNED_EN to treat in_data as two's complement with digit DIGITS-1 used as the sign.
//
// state | meaning
// IDLE  | waiting for in_valid; seg/ovf hold the last result
// CONV  | shifting one magnitude bit per clock into the BCD register
module seg7_bcd_display #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5,
  parameter bit LZB    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg
);

  // BCD register sized for the full input range, and never narrower than the display
  localparam int BCD_MIN = (DATA_W * 3) / 10 + 1;
  localparam int BCD_N   = (BCD_MIN > DIGITS) ? BCD_MIN : DIGITS;
  localparam int CNT_W   = $clog2(DATA_W + 1);
`ifdef SEG7_SIGNED_EN
  localparam int MAG_D   = DIGITS - 1;
`else
  localparam int MAG_D   = DIGITS;
`endif

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LIMIT = pow10_m1(MAG_D);

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    mag_q, mag_in, mag_nxt;
  logic [4*BCD_N-1:0]   bcd_q, bcd_adj, bcd_nxt;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q, ovf_in, last;
  logic [7*DIGITS-1:0]  seg_nxt;
  logic [3:0]           dig;
  logic                 nz;
`ifdef SEG7_SIGNED_EN
  logic                 neg_q, neg_in;
`endif

  assign busy = (state_q == CONV);
  assign last = (cnt_q == CNT_W'(1));

  always_comb begin
`ifdef SEG7_SIGNED_EN
    neg_in = in_data[DATA_W-1];
    mag_in = neg_in ? (~in_data + 1'b1) : in_data;
`else
    mag_in = in_data;
`endif
    ovf_in = {{(64-DATA_W){1'b0}}, mag_in} > LIMIT;
  end

  // one double-dabble iteration: correct nibbles >= 5, then shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_N; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    {bcd_nxt, mag_nxt} = {bcd_adj, mag_q} << 1;
  end

  // patterns derived from the post-iteration BCD so they are ready on the final edge
  always_comb begin
    seg_nxt = '1;
    nz      = 1'b0;
    dig     = 4'd0;
    for (int k = MAG_D - 1; k >= 0; k--) begin
      dig = bcd_nxt[4*k +: 4];
      if (dig != 4'd0 || k == 0) nz = 1'b1;
      if (LZB && !nz) seg_nxt[7*k +: 7] = SEG_BLANK;
      else            seg_nxt[7*k +: 7] = enc(dig);
    end
`ifdef SEG7_SIGNED_EN
    seg_nxt[7*(DIGITS-1) +: 7] = neg_q ? SEG_DASH : SEG_BLANK;
`endif
    if (ovf_q) seg_nxt = {DIGITS{SEG_DASH}};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONV;
      CONV:    if (last)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      seg   <= {DIGITS{SEG_BLANK}};
      ovf   <= 1'b0;
      done  <= 1'b0;
`ifdef SEG7_SIGNED_EN
      neg_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q <= mag_in;
            ovf_q <= ovf_in;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
`ifdef SEG7_SIGNED_EN
            neg_q <= neg_in;
`endif
          end
        end
        CONV: begin
          mag_q <= mag_nxt;
          bcd_q <= bcd_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (last) begin
            seg  <= seg_nxt;
            ovf  <= ovf_q;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Scoreboard bench for seg7_bcd_display: three instances (defaults, LZB=0, DIGITS=4) share one stimulus stream.
// Expected patterns come from a decimal-arithmetic model; build with SEG7_SIGNED_EN to cover signed display.
module tb_seg7_bcd_display;

  localparam int W = 16;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  logic [34:0] seg0, seg1;
  logic [27:0] seg2;

  int n_chk = 0, n_fail = 0, cyc = 0;

  typedef struct {
    logic [55:0] s0, s1, s2;
    logic        o0, o1, o2;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [55:0] shown0, shown2;
  logic        done_prev;
  logic [6:0]  enc_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg7_bcd_display #(.DATA_W(W), .DIGITS(5), .LZB(1'b1)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy0), .done(done0), .ovf(ovf0), .seg(seg0));
  seg7_bcd_display #(.DATA_W(W), .DIGITS(5), .LZB(1'b0)) u_nolzb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy1), .done(done1), .ovf(ovf1), .seg(seg1));
  seg7_bcd_display #(.DATA_W(W), .DIGITS(4), .LZB(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy2), .done(done2), .ovf(ovf2), .seg(seg2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", nm, why, $time);
  endtask

  // Decimal reference: digit k = (mag / 10^k) % 10, blanked when above the top non-zero digit.
  function automatic void model(input logic [15:0] v, input int nd, input bit lzb,
                                output logic [55:0] s, output logic ov);
    longint mag, lim, p;
    bit neg;
    int md;
`ifdef SEG7_SIGNED_EN
    neg = v[15];
    mag = neg ? (longint'(65536) - longint'(v)) : longint'(v);
    md  = nd - 1;
`else
    neg = 1'b0;
    mag = longint'(v);
    md  = nd;
`endif
    lim = 1;
    for (int i = 0; i < md; i++) lim = lim * 10;
    lim = lim - 1;
    ov = (mag > lim);
    s  = '0;
    p  = 1;
    for (int k = 0; k < nd; k++) begin
      if (ov)                           s[7*k +: 7] = DASH;
      else if (k >= md)                 s[7*k +: 7] = neg ? DASH : BLANK;
      else if (lzb && k > 0 && mag < p) s[7*k +: 7] = BLANK;
      else                              s[7*k +: 7] = enc_tbl[int'((mag / p) % 10)];
      p = p * 10;
    end
  endfunction

  task automatic push_exp(input logic [15:0] v);
    exp_t e;
    model(v, 5, 1'b1, e.s0, e.o0);
    model(v, 5, 1'b0, e.s1, e.o1);
    model(v, 4, 1'b1, e.s2, e.o2);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse; between pulses the display must not move.
  always @(negedge clk) begin
    if (!rst) begin
      shown0    <= {8{BLANK}};
      shown2    <= {8{BLANK}};
      done_prev <= 1'b0;
    end else begin
      if (done0) begin
        chk("done_single_cycle", 64'(done_prev), 64'd0);
        chk("done_all_instances", 64'({done1, done2}), 64'd3);
        chk("busy_low_at_done", 64'({busy0, busy1, busy2}), 64'd0);
        if (sb.size() == 0) begin
          fail_now("unexpected_done", "done pulse with no accepted request pending");
        end else begin
          chk("latency", 64'(cyc - sb[0].acc), 64'd16);
          chk("seg_lzb1", 64'(seg0), 64'(sb[0].s0[34:0]));
          chk("ovf_lzb1", 64'(ovf0), 64'(sb[0].o0));
          chk("seg_lzb0", 64'(seg1), 64'(sb[0].s1[34:0]));
          chk("ovf_lzb0", 64'(ovf1), 64'(sb[0].o1));
          chk("seg_dig4", 64'(seg2), 64'(sb[0].s2[27:0]));
          chk("ovf_dig4", 64'(ovf2), 64'(sb[0].o2));
          shown0 <= sb[0].s0;
          shown2 <= sb[0].s2;
          sb.delete(0);
        end
      end else begin
        chk("seg_hold_main", 64'(seg0), 64'(shown0[34:0]));
        chk("seg_hold_dig4", 64'(seg2), 64'(shown2[27:0]));
        if (sb.size() != 0 && (cyc - sb[0].acc) >= 1 && (cyc - sb[0].acc) <= 15)
          chk("busy_during_conv", 64'(busy0), 64'd1);
      end
      done_prev <= done0;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy0 !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy0 !== 1'b0) fail_now("wait_idle", "busy never fell within 40 cycles");
  endtask

  task automatic convert(input logic [15:0] v, input int gap);
    wait_idle();
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    chk("accept_busy", 64'(busy0), 64'd1);
    push_exp(v);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("drain_timeout", "expected done pulse never arrived");
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_seg_main"}, 64'(seg0), 64'({5{BLANK}}));
    chk({tag, "_seg_nolzb"}, 64'(seg1), 64'({5{BLANK}}));
    chk({tag, "_seg_dig4"}, 64'(seg2), 64'({4{BLANK}}));
    chk({tag, "_busy"}, 64'({busy0, busy1, busy2}), 64'd0);
    chk({tag, "_done"}, 64'({done0, done1, done2}), 64'd0);
    chk({tag, "_ovf"}, 64'({ovf0, ovf1, ovf2}), 64'd0);
  endtask

  initial begin
    logic [15:0] v;
    logic [55:0] s_exp;
    logic        o_exp;
    int          t;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    #1 rst = 1'b1;
    @(negedge clk);

    convert(16'd12345, 0);
    drain();
`ifndef SEG7_SIGNED_EN
    chk("vec_12345", 64'(seg0), 64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12}));
`endif

    convert(16'd0, 0);
    drain();
    chk("vec_zero_lzb1", 64'(seg0), 64'({BLANK, BLANK, BLANK, BLANK, 7'h40}));

    convert(16'd507, 0);
    drain();
`ifndef SEG7_SIGNED_EN
    chk("vec_507_lzb1", 64'(seg0), 64'({BLANK, BLANK, 7'h12, 7'h40, 7'h78}));
    chk("vec_507_lzb0", 64'(seg1), 64'({7'h40, 7'h40, 7'h12, 7'h40, 7'h78}));
`endif

    convert(16'd10000, 0);
    drain();
    chk("vec_10000_dig4_seg", 64'(seg2), 64'({4{DASH}}));
    chk("vec_10000_dig4_ovf", 64'(ovf2), 64'd1);

    convert(16'd9999, 0);
    drain();
`ifndef SEG7_SIGNED_EN
    chk("vec_9999_dig4_seg", 64'(seg2), 64'({4{7'h10}}));
    chk("vec_9999_dig4_ovf", 64'(ovf2), 64'd0);
`endif

    // request held high; data changes during busy must not start a second conversion
    wait_idle();
    in_valid = 1'b1;
    in_data  = 16'd111;
    @(negedge clk);
    chk("hold_accept_busy", 64'(busy0), 64'd1);
    push_exp(16'd111);
    in_data = 16'd222;
    t = 0;
    while (done0 !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (done0 !== 1'b1) fail_now("hold_done_timeout", "no done pulse for held request");
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_not_reaccepted", 64'(busy0), 64'd0);
    model(16'd111, 5, 1'b1, s_exp, o_exp);
    chk("hold_shows_111", 64'(seg0), 64'(s_exp[34:0]));

    convert(16'hFFD6, 0);
    drain();
`ifdef SEG7_SIGNED_EN
    chk("vec_neg42", 64'(seg0), 64'({DASH, BLANK, BLANK, 7'h19, 7'h24}));
`endif

    convert(16'h8000, 0);
    convert(16'hFFFF, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom);
        1:       v = 16'($urandom_range(0, 9));
        2:       v = 16'($urandom_range(0, 9999));
        default: v = 16'($urandom_range(9995, 10005));
      endcase
      convert(v, int'($urandom_range(0, 2)));
    end
    drain();

    // reset during a conversion aborts it with no done pulse
    convert(16'd4321, 0);
    repeat (7) @(negedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state("abort");
    #1 rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_seg_blank", 64'(seg0), 64'({5{BLANK}}));
    chk("abort_idle", 64'(busy0), 64'd0);

    convert(16'd4321, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
